// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between boot (0), data (1) and fetch (2) requesters, one transaction at a time.
// Latency: gnt one cycle after req is sampled, done RAM_LAT+2 cycles after sampling (2 on a bounds error).
// Backpressure: req is sampled only in IDLE; `define ARB_RR_EN alternates ports 1/2 round-robin.
module ram_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MEM_SIZE = 4096,
    parameter int RAM_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [2:0]            size,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic                  ram_size,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [ADDR_W:0] MEM_LIM   = (ADDR_W+1)'(MEM_SIZE);
    localparam logic [ADDR_W:0] WORD_SPAN = (ADDR_W+1)'(DATA_W/8 - 1);
    localparam logic [2:0]      LAT_LAST  = 3'(RAM_LAT - 1);

    state_t state, state_nxt;

    logic                win_vld;
    logic [1:0]          win;
    logic                sel_we, sel_size, sel_err;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [ADDR_W:0]     span_end;

    logic                lat_we, lat_size, lat_err;
    logic [1:0]          lat_port;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [2:0]          cnt;

`ifdef ARB_RR_EN
    logic                rr_prefer2;
`endif

    // Winner selection: port 0 always first; ports 1/2 fixed or round-robin
    always_comb begin
        win_vld = |req;
        win     = 2'd0;
`ifdef ARB_RR_EN
        if (req[0])                 win = 2'd0;
        else if (req[1] && req[2])  win = rr_prefer2 ? 2'd2 : 2'd1;
        else if (req[1])            win = 2'd1;
        else if (req[2])            win = 2'd2;
`else
        if (req[0])                 win = 2'd0;
        else if (req[1])            win = 2'd1;
        else if (req[2])            win = 2'd2;
`endif
    end

    always_comb begin
        sel_we   = we[win];
        sel_size = size[win];
        case (win)
            2'd0:    begin sel_addr = addr[0 +: ADDR_W];        sel_wdata = wdata[0 +: DATA_W];        end
            2'd1:    begin sel_addr = addr[ADDR_W +: ADDR_W];   sel_wdata = wdata[DATA_W +: DATA_W];   end
            default: begin sel_addr = addr[2*ADDR_W +: ADDR_W]; sel_wdata = wdata[2*DATA_W +: DATA_W]; end
        endcase
        // One extra bit so a word near the top of the address space cannot wrap to 0
        span_end = {1'b0, sel_addr} + (sel_size ? WORD_SPAN : '0);
        sel_err  = (span_end >= MEM_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ACCESS;
            ACCESS:  state_nxt = lat_err ? RESP : WAIT;
            WAIT:    if (cnt == LAT_LAST) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we     <= 1'b0;
            lat_size   <= 1'b0;
            lat_err    <= 1'b0;
            lat_port   <= 2'd0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= 3'd0;
            rdata      <= '0;
`ifdef ARB_RR_EN
            rr_prefer2 <= 1'b0;
`endif
        end else begin
            if (state == IDLE && win_vld) begin
                lat_we    <= sel_we;
                lat_size  <= sel_size;
                lat_err   <= sel_err;
                lat_port  <= win;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
`ifdef ARB_RR_EN
                if (win != 2'd0) rr_prefer2 <= (win == 2'd1);
`endif
            end
            if (state == ACCESS)    cnt <= 3'd0;
            else if (state == WAIT) cnt <= cnt + 3'd1;
            // The edge entering RESP is exactly RAM_LAT cycles after ACCESS
            if (state != RESP && state_nxt == RESP) begin
                if (lat_we || lat_err) rdata <= '0;
                else if (lat_size)     rdata <= ram_rdata;
                else                   rdata <= {{(DATA_W-8){1'b0}}, ram_rdata[7:0]};
            end
        end
    end

    always_comb begin
        gnt       = 3'b000;
        done      = 3'b000;
        err       = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_size  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ACCESS: begin
                gnt = 3'b001 << lat_port;
                if (!lat_err) begin
                    ram_en    = 1'b1;
                    ram_we    = lat_we;
                    ram_size  = lat_size;
                    ram_addr  = lat_addr;
                    ram_wdata = lat_wdata;
                end
            end
            RESP: begin
                done = 3'b001 << lat_port;
                err  = lat_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance a (RAM_LAT=1) and instance b (RAM_LAT=4) share stimulus,
// each with its own little-endian byte RAM model.
module tb_ram_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [2:0]  req, we, size;
    logic [47:0] addr;
    logic [95:0] wdata;

    logic [2:0]  gnt_a, done_a, gnt_b, done_b;
    logic        err_a, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ram_en_a, ram_we_a, ram_size_a, ram_en_b, ram_we_b, ram_size_b;
    logic [15:0] ram_addr_a, ram_addr_b;
    logic [31:0] ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_SIZE(4096), .RAM_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst_a), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
        .gnt(gnt_a), .done(done_a), .err(err_a), .rdata(rdata_a),
        .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_size(ram_size_a), .ram_addr(ram_addr_a),
        .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
    );

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_SIZE(4096), .RAM_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst_b), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
        .gnt(gnt_b), .done(done_b), .err(err_b), .rdata(rdata_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_size(ram_size_b), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
    );

    // RAM models: read data is only valid in the cycle RAM_LAT after ram_en, garbage otherwise
    logic [7:0]       mem_a [0:4095];
    logic [7:0]       mem_b [0:4095];
    logic [3:0][31:0] pipe_a, pipe_b;
    logic [3:0]       pv_a = 4'b0, pv_b = 4'b0;

    always @(posedge clk) begin : ram_model_a
        logic [11:0] i;
        i = ram_addr_a[11:0];
        pv_a   <= {pv_a[2:0], ram_en_a && !ram_we_a};
        pipe_a <= {pipe_a[2:0], ram_size_a ? {mem_a[i+12'd3], mem_a[i+12'd2], mem_a[i+12'd1], mem_a[i]}
                                           : {24'hA5A5A5, mem_a[i]}};
        if (ram_en_a && ram_we_a) begin
            mem_a[i] <= ram_wdata_a[7:0];
            if (ram_size_a) begin
                mem_a[i+12'd1] <= ram_wdata_a[15:8];
                mem_a[i+12'd2] <= ram_wdata_a[23:16];
                mem_a[i+12'd3] <= ram_wdata_a[31:24];
            end
        end
    end

    always @(posedge clk) begin : ram_model_b
        logic [11:0] i;
        i = ram_addr_b[11:0];
        pv_b   <= {pv_b[2:0], ram_en_b && !ram_we_b};
        pipe_b <= {pipe_b[2:0], ram_size_b ? {mem_b[i+12'd3], mem_b[i+12'd2], mem_b[i+12'd1], mem_b[i]}
                                           : {24'hA5A5A5, mem_b[i]}};
        if (ram_en_b && ram_we_b) begin
            mem_b[i] <= ram_wdata_b[7:0];
            if (ram_size_b) begin
                mem_b[i+12'd1] <= ram_wdata_b[15:8];
                mem_b[i+12'd2] <= ram_wdata_b[23:16];
                mem_b[i+12'd3] <= ram_wdata_b[31:24];
            end
        end
    end

    assign ram_rdata_a = pv_a[LAT_A-1] ? pipe_a[LAT_A-1] : 32'h5A5A5A5A;
    assign ram_rdata_b = pv_b[LAT_B-1] ? pipe_b[LAT_B-1] : 32'h5A5A5A5A;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          port;
        logic        we;
        logic        size;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(int port, logic w, logic s, logic [15:0] a, logic [31:0] d);
        we[port]              = w;
        size[port]            = s;
        addr[port*16 +: 16]   = a;
        wdata[port*32 +: 32]  = d;
    endtask

    task automatic chk_zero(string tag, logic [2:0] g, logic [2:0] d, logic e, logic [31:0] rd,
                            logic en, logic w, logic s, logic [15:0] a, logic [31:0] wd);
        chk({tag, " ctl"},   {22'b0, g, d, e, en, w, s}, 32'h0);
        chk({tag, " rdata"}, rd, 32'h0);
        chk({tag, " addr"},  {16'b0, a}, 32'h0);
        chk({tag, " wdata"}, wd, 32'h0);
    endtask

    function automatic int gidx(logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 3;
        endcase
    endfunction

    // One transaction on both instances; req dropped at gnt
    task automatic apply(string tag, vec_t v);
        int          kda = 0, kdb = 0, ena = 0, enb = 0;
        logic [2:0]  oh, da = 3'b0, db = 3'b0;
        logic        ea = 1'b0, eb = 1'b0;
        logic [31:0] ra = 32'h0, rb = 32'h0;
        oh = 3'b001 << v.port;
        drive(v.port, v.we, v.size, v.addr, v.wdata);
        req = oh;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, " gnt_a"}, {29'b0, gnt_a}, {29'b0, oh});
                chk({tag, " gnt_b"}, {29'b0, gnt_b}, {29'b0, oh});
                req = 3'b000;
            end
            ena += int'(ram_en_a);
            enb += int'(ram_en_b);
            if (kda == 0 && done_a != 3'b0) begin kda = k; da = done_a; ea = err_a; ra = rdata_a; end
            if (kdb == 0 && done_b != 3'b0) begin kdb = k; db = done_b; eb = err_b; rb = rdata_b; end
        end
        chk({tag, " done_cyc_a"}, kda, v.err ? 2 : 2 + LAT_A);
        chk({tag, " done_cyc_b"}, kdb, v.err ? 2 : 2 + LAT_B);
        chk({tag, " done_a"}, {29'b0, da}, {29'b0, oh});
        chk({tag, " done_b"}, {29'b0, db}, {29'b0, oh});
        chk({tag, " err_a"}, {31'b0, ea}, {31'b0, v.err});
        chk({tag, " err_b"}, {31'b0, eb}, {31'b0, v.err});
        chk({tag, " rdata_a"}, ra, v.rdata);
        chk({tag, " rdata_b"}, rb, v.rdata);
        chk({tag, " ram_en_a"}, ena, v.err ? 0 : 1);
        chk({tag, " ram_en_b"}, enb, v.err ? 0 : 1);
    endtask

    initial begin
        int ord[4];
        int exp_hold[4];
        int got;
        int stray;

        tbl[0]  = '{1, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h00000000};
        tbl[1]  = '{1, 1'b0, 1'b1, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{2, 1'b0, 1'b0, 16'h0011, 32'h0,        1'b0, 32'h000000BE};
        tbl[3]  = '{1, 1'b1, 1'b1, 16'h0FFC, 32'h12345678, 1'b0, 32'h00000000};
        tbl[4]  = '{1, 1'b0, 1'b1, 16'h0FFC, 32'h0,        1'b0, 32'h12345678};
        tbl[5]  = '{1, 1'b1, 1'b1, 16'h0FFD, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        tbl[6]  = '{2, 1'b0, 1'b1, 16'h0FFD, 32'h0,        1'b1, 32'h00000000};
        tbl[7]  = '{1, 1'b0, 1'b0, 16'h1000, 32'h0,        1'b1, 32'h00000000};
        tbl[8]  = '{1, 1'b0, 1'b0, 16'h0FFF, 32'h0,        1'b0, 32'h00000012};
        tbl[9]  = '{0, 1'b0, 1'b1, 16'hFFFE, 32'h0,        1'b1, 32'h00000000};
        tbl[10] = '{0, 1'b1, 1'b1, 16'h0000, 32'h44332211, 1'b0, 32'h00000000};
        tbl[11] = '{0, 1'b0, 1'b1, 16'h0000, 32'h0,        1'b0, 32'h44332211};
        tbl[12] = '{2, 1'b1, 1'b0, 16'h0012, 32'hCAFEF0A7, 1'b0, 32'h00000000};
        tbl[13] = '{1, 1'b0, 1'b1, 16'h0010, 32'h0,        1'b0, 32'hDEA7BEEF};

        rst_a = 1'b1; rst_b = 1'b1;
        req = 3'b0; we = 3'b0; size = 3'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset a", gnt_a, done_a, err_a, rdata_a, ram_en_a, ram_we_a, ram_size_a, ram_addr_a, ram_wdata_a);
        chk_zero("reset b", gnt_b, done_b, err_b, rdata_b, ram_en_b, ram_we_b, ram_size_b, ram_addr_b, ram_wdata_b);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Arbitration on instance a only; b parked in reset
        rst_b = 1'b1; rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        drive(0, 1'b0, 1'b1, 16'h0000, 32'h0);
        drive(1, 1'b0, 1'b1, 16'h0010, 32'h0);
        drive(2, 1'b0, 1'b1, 16'h0FFC, 32'h0);
        req = 3'b111;
        got = 0;
        ord = '{9, 9, 9, 9};
        for (int c = 0; c < 60 && got < 3; c++) begin
            @(negedge clk);
            if (gnt_a != 3'b0) begin
                ord[got] = gidx(gnt_a);
                got++;
                req = req & ~gnt_a;
            end
        end
        req = 3'b000;
        chk("arb111 grants", got, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("arb111 order%0d", i), ord[i], i);
        repeat (10) @(negedge clk);

`ifdef ARB_RR_EN
        exp_hold = '{1, 2, 1, 2};
`else
        exp_hold = '{1, 1, 1, 1};
`endif
        req = 3'b110;
        got = 0;
        ord = '{9, 9, 9, 9};
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clk);
            if (gnt_a != 3'b0) begin
                ord[got] = gidx(gnt_a);
                got++;
            end
        end
        req = 3'b000;
        chk("arb110 grants", got, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("arb110 order%0d", i), ord[i], exp_hold[i]);
        repeat (10) @(negedge clk);

        // Reset instance b while it waits on RAM data
        rst_b = 1'b0;
        @(negedge clk);
        apply("prerst", tbl[13]);
        drive(1, 1'b0, 1'b1, 16'h0010, 32'h0);
        req = 3'b010;
        @(negedge clk);
        chk("midrst gnt_b", {29'b0, gnt_b}, 32'h2);
        req = 3'b000;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk_zero("midrst b", gnt_b, done_b, err_b, rdata_b, ram_en_b, ram_we_b, ram_size_b, ram_addr_b, ram_wdata_b);
        @(negedge clk);
        rst_b = 1'b0;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_b != 3'b0) stray++;
        end
        chk("midrst no done_b", stray, 0);
        apply("postrst", tbl[4]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
